// File: rtl/biquad_sequencer.sv
// rtl/biquad_sequencer.sv - time-multiplexed direct-form-I biquad controller
// One shared MAC evaluates the five taps from an external synchronous coefficient ROM.
module biquad_sequencer #(
   parameter int COEF_W          = 32,
   parameter int SHIFT           = 30,
   parameter int ACC_W           = 64,
   parameter int CLEAR_ON_SWITCH = 1
) (
   input  logic              clk_48,
   input  logic              reset,
   input  logic              sample_valid,
   input  logic [15:0]       sample_in,
   input  logic [2:0]        filter,
   output logic [5:0]        coef_addr,
   input  logic [COEF_W-1:0] coef_data,
   output logic [15:0]       sample_out,
   output logic              out_valid,
   output logic              busy,
   output logic              overrun,
   input  logic              clr_overrun
);

   typedef enum logic [1:0] {IDLE, FETCH, MAC, WRITE} state_t;

   localparam logic signed [ACC_W-1:0] SAT_MAX = 32767;
   localparam logic signed [ACC_W-1:0] SAT_MIN = -32768;

   state_t                  state, state_nxt;
   logic [2:0]              tap, filter_latched;
   logic signed [15:0]      x0, x1, x2, y1, y2;
   logic signed [15:0]      operand, sat;
   logic signed [ACC_W-1:0] acc, coef_ext, opnd_ext, prod, term;

   assign coef_addr = {filter_latched, tap};

   // ROM data arriving in MAC belongs to the address issued one cycle earlier (tap-1)
   always_comb begin
      operand = '0;
      case (tap)
         3'd1:    operand = x0;
         3'd2:    operand = x1;
         3'd3:    operand = x2;
         3'd4:    operand = y1;
         3'd5:    operand = y2;
         default: operand = '0;
      endcase
   end

   assign coef_ext = {{(ACC_W-COEF_W){coef_data[COEF_W-1]}}, coef_data};
   assign opnd_ext = {{(ACC_W-16){operand[15]}}, operand};
   assign prod     = coef_ext * opnd_ext;
   assign term     = prod >>> SHIFT;

   always_comb begin
      sat = acc[15:0];
      if (acc > SAT_MAX)
         sat = 16'sh7FFF;
      else if (acc < SAT_MIN)
         sat = 16'sh8000;
   end

   always_ff @(posedge clk_48 or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sample_valid) state_nxt = FETCH;
         FETCH:   state_nxt = MAC;
         MAC:     if (tap == 3'd5) state_nxt = WRITE;
         WRITE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_48 or posedge reset) begin
      if (reset) begin
         tap            <= '0;
         acc            <= '0;
         x0             <= '0;
         x1             <= '0;
         x2             <= '0;
         y1             <= '0;
         y2             <= '0;
         filter_latched <= '0;
         sample_out     <= '0;
         out_valid      <= 1'b0;
         busy           <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         // a dropped request outranks a simultaneous clear
         if (sample_valid && state != IDLE)
            overrun <= 1'b1;
         else if (clr_overrun)
            overrun <= 1'b0;

         case (state)
            IDLE: begin
               if (sample_valid) begin
                  x0             <= sample_in;
                  filter_latched <= filter;
                  tap            <= '0;
                  busy           <= 1'b1;
                  if (CLEAR_ON_SWITCH != 0 && filter != filter_latched) begin
                     x1 <= '0;
                     x2 <= '0;
                     y1 <= '0;
                     y2 <= '0;
                  end
               end
            end
            FETCH: tap <= tap + 3'd1;
            MAC: begin
               acc <= acc + term;
               tap <= tap + 3'd1;
            end
            WRITE: begin
               sample_out <= sat;
               out_valid  <= 1'b1;
               busy       <= 1'b0;
               x2         <= x1;
               x1         <= x0;
               y2         <= y1;
               y1         <= sat;
               acc        <= '0;
               tap        <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_biquad_sequencer.sv
// tb/tb_biquad_sequencer.sv - directed self-checking bench for biquad_sequencer
module tb_biquad_sequencer;

   logic        clk_48 = 1'b0;
   logic        reset = 1'b1;
   logic        sample_valid = 1'b0;
   logic [15:0] sample_in = '0;
   logic [2:0]  filter = '0;
   logic [5:0]  coef_addr;
   logic [31:0] coef_data = '0;
   logic [15:0] sample_out;
   logic        out_valid;
   logic        busy;
   logic        overrun;
   logic        clr_overrun = 1'b0;

   logic [31:0] rom [0:63];
   int          checks = 0;
   int          errors = 0;

   biquad_sequencer dut (
      .clk_48      (clk_48),
      .reset       (reset),
      .sample_valid(sample_valid),
      .sample_in   (sample_in),
      .filter      (filter),
      .coef_addr   (coef_addr),
      .coef_data   (coef_data),
      .sample_out  (sample_out),
      .out_valid   (out_valid),
      .busy        (busy),
      .overrun     (overrun),
      .clr_overrun (clr_overrun)
   );

   always #5 clk_48 = ~clk_48;

   // synchronous coefficient ROM, one clock of latency
   always @(posedge clk_48) coef_data <= rom[coef_addr];

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // advance until out_valid, starting from edge count n; returns edge index of the pulse
   task automatic wait_result(input int start, output int n);
      n = start;
      while (!out_valid && n < 20) begin
         @(posedge clk_48);
         #1;
         n++;
      end
   endtask

   task automatic run(input logic [15:0] s, input logic [2:0] f, input logic [15:0] exp, input string tag);
      int n;
      @(negedge clk_48);
      sample_valid = 1'b1;
      sample_in    = s;
      filter       = f;
      @(posedge clk_48);
      #1 sample_valid = 1'b0;
      check({tag, "_busy"}, 16'(busy), 16'd1);
      wait_result(0, n);
      check({tag, "_lat"}, 16'(n), 16'd7);
      check({tag, "_out"}, sample_out, exp);
   endtask

   initial begin
      int  n;
      logic seen;
      for (int i = 0; i < 64; i++) rom[i] = '0;
      repeat (3) @(posedge clk_48);
      #1;
      check("rst_out", sample_out, 16'h0000);
      check("rst_ov", 16'(out_valid), 16'd0);
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_overrun", 16'(overrun), 16'd0);
      check("rst_addr", 16'(coef_addr), 16'h0000);
      @(negedge clk_48);
      reset = 1'b0;

      // passthrough on filter 1
      rom[8] = 32'h4000_0000;
      run(16'd1000, 3'd1, 16'd1000, "pt_pos");
      run(16'hFC18, 3'd1, 16'hFC18, "pt_neg");

      // recursion y = x + 0.5*y1 on filter 3 (switch clears history)
      rom[24] = 32'h4000_0000;
      rom[27] = 32'h2000_0000;
      run(16'd1024, 3'd3, 16'd1024, "rec0");
      run(16'd0, 3'd3, 16'd512, "rec1");
      run(16'd0, 3'd3, 16'd256, "rec2");
      run(16'd0, 3'd3, 16'd128, "rec3");

      // saturation on filter 4, then read y1 back through tap 3
      rom[32] = 32'h7FFF_FFFF;
      run(16'd20000, 3'd4, 16'h7FFF, "sat_pos");
      run(16'hB1E0, 3'd4, 16'h8000, "sat_neg");
      rom[32] = 32'h0;
      rom[35] = 32'h4000_0000;
      run(16'd0, 3'd4, 16'h8000, "sat_y1");

      // overrun: second request at edge 3 is dropped
      @(negedge clk_48);
      sample_valid = 1'b1;
      sample_in    = 16'd500;
      filter       = 3'd1;
      @(posedge clk_48);
      #1 sample_valid = 1'b0;
      repeat (2) @(posedge clk_48);
      @(negedge clk_48);
      sample_valid = 1'b1;
      sample_in    = 16'd3000;
      filter       = 3'd5;
      @(posedge clk_48);
      #1 sample_valid = 1'b0;
      check("ovr_set", 16'(overrun), 16'd1);
      check("ovr_busy", 16'(busy), 16'd1);
      wait_result(3, n);
      check("ovr_lat", 16'(n), 16'd7);
      check("ovr_out", sample_out, 16'd500);
      @(negedge clk_48);
      clr_overrun = 1'b1;
      @(posedge clk_48);
      #1 clr_overrun = 1'b0;
      check("ovr_clr", 16'(overrun), 16'd0);

      // set wins over a simultaneous clear
      @(negedge clk_48);
      sample_valid = 1'b1;
      sample_in    = 16'd500;
      filter       = 3'd1;
      @(posedge clk_48);
      #1 sample_valid = 1'b0;
      @(negedge clk_48);
      sample_valid = 1'b1;
      clr_overrun  = 1'b1;
      @(posedge clk_48);
      #1 sample_valid = 1'b0;
      clr_overrun = 1'b0;
      check("ovr_setwins", 16'(overrun), 16'd1);
      wait_result(1, n);
      check("ovr2_out", sample_out, 16'd500);
      @(negedge clk_48);
      clr_overrun = 1'b1;
      @(posedge clk_48);
      #1 clr_overrun = 1'b0;
      check("ovr_clr2", 16'(overrun), 16'd0);

      // filter switch: history x1=y1=500 would give 1100 if not cleared
      rom[16] = 32'h4000_0000;
      rom[17] = 32'h4000_0000;
      rom[19] = 32'h4000_0000;
      @(negedge clk_48);
      sample_valid = 1'b1;
      sample_in    = 16'd100;
      filter       = 3'd2;
      @(posedge clk_48);
      #1 sample_valid = 1'b0;
      check("sw_addr0", 16'(coef_addr), 16'h0010);
      for (int i = 1; i < 5; i++) begin
         @(posedge clk_48);
         #1;
         check($sformatf("sw_addr%0d", i), 16'(coef_addr), 16'(16 + i));
      end
      wait_result(4, n);
      check("sw_lat", 16'(n), 16'd7);
      check("sw_out", sample_out, 16'd100);

      // asynchronous reset at edge 4 of a sequence
      @(negedge clk_48);
      sample_valid = 1'b1;
      sample_in    = 16'd50;
      filter       = 3'd2;
      @(posedge clk_48);
      #1 sample_valid = 1'b0;
      repeat (4) @(posedge clk_48);
      #1 reset = 1'b1;
      #1;
      check("ar_out", sample_out, 16'h0000);
      check("ar_ov", 16'(out_valid), 16'd0);
      check("ar_busy", 16'(busy), 16'd0);
      check("ar_addr", 16'(coef_addr), 16'h0000);
      @(negedge clk_48);
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk_48);
         if (out_valid) seen = 1'b1;
      end
      check("ar_nopulse", 16'(seen), 16'd0);
      run(16'd50, 3'd2, 16'd50, "ar_after");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
